// File: rtl/alu_seq_unit_if.sv
// Request/response bundle between an initiator and the sequential ALU responder.
// The initiator uses the master modport and the ALU uses the slave modport.
interface alu_seq_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_z;
    logic        rsp_equal;
    logic        rsp_overflow;
    logic        rsp_zero;
    logic        busy;

    modport master (
        output req_valid, req_op, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_z, rsp_equal, rsp_overflow, rsp_zero, busy
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_z, rsp_equal, rsp_overflow, rsp_zero, busy
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Handshaked ALU responder: single-cycle AND/ADD/SUB/SLT, iterative shifts of
// SHIFT_STEP bits per cycle, one transaction outstanding at a time.
module alu_seq_unit #(
    parameter int SHIFT_STEP = 1
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_unit_if.slave bus
);
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SLT = 3'd3;
    localparam logic [2:0] OP_SRL = 3'd4;
    localparam logic [2:0] OP_SRA = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    logic [1:0]  state;
    logic [2:0]  op_q;
    logic [31:0] acc;
    logic [4:0]  cnt;
    logic        eq_pend;
    logic [31:0] z_q;
    logic        eq_q;
    logic        ov_q;
    logic        zero_q;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] imm_z;
    logic        imm_ov;
    logic        imm_eq;
    logic        is_shift;
    logic [4:0]  step;
    logic [4:0]  cnt_nxt;
    logic [31:0] shifted;

    assign sum      = bus.req_x + bus.req_y;
    assign diff     = bus.req_x - bus.req_y;
    assign is_shift = (bus.req_op == OP_SRL) || (bus.req_op == OP_SRA) || (bus.req_op == OP_SLL);
    assign imm_eq   = (bus.req_x == bus.req_y) && (bus.req_op != OP_RSV);

    // Single-cycle result; a shift only lands here when its amount is zero.
    always_comb begin
        imm_z  = '0;
        imm_ov = 1'b0;
        case (bus.req_op)
            OP_AND: imm_z = bus.req_x & bus.req_y;
            OP_ADD: begin
                imm_z  = sum;
                imm_ov = (bus.req_x[31] == bus.req_y[31]) && (sum[31] != bus.req_x[31]);
            end
            OP_SUB: begin
                imm_z  = diff;
                imm_ov = (bus.req_x[31] != bus.req_y[31]) && (diff[31] != bus.req_x[31]);
            end
            OP_SLT: imm_z = {31'b0, $signed(bus.req_x) < $signed(bus.req_y)};
            OP_SRL, OP_SRA, OP_SLL: imm_z = bus.req_x;
            default: imm_z = '0;
        endcase
    end

    // Last step may be partial so the total shift is exact.
    assign step    = (cnt < STEP) ? cnt : STEP;
    assign cnt_nxt = cnt - step;

    always_comb begin
        shifted = acc;
        case (op_q)
            OP_SRL:  shifted = acc >> step;
            OP_SRA:  shifted = $signed(acc) >>> step;
            default: shifted = acc << step;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= '0;
            acc     <= '0;
            cnt     <= '0;
            eq_pend <= 1'b0;
            z_q     <= '0;
            eq_q    <= 1'b0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q    <= bus.req_op;
                        eq_pend <= imm_eq;
                        if (is_shift && (bus.req_y[4:0] != 5'd0)) begin
                            acc   <= bus.req_x;
                            cnt   <= bus.req_y[4:0];
                            state <= S_SHIFT;
                        end else begin
                            z_q    <= imm_z;
                            eq_q   <= imm_eq;
                            ov_q   <= imm_ov;
                            zero_q <= (bus.req_op != OP_RSV) && (imm_z == 32'd0);
                            state  <= S_RESP;
                        end
                    end
                end
                S_SHIFT: begin
                    acc <= shifted;
                    cnt <= cnt_nxt;
                    // Response registers move only on entry to RESP so they hold
                    // the previous result while the shift is in flight.
                    if (cnt_nxt == 5'd0) begin
                        z_q    <= shifted;
                        eq_q   <= eq_pend;
                        ov_q   <= 1'b0;
                        zero_q <= (shifted == 32'd0);
                        state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = (state == S_IDLE);
    assign bus.rsp_valid    = (state == S_RESP);
    assign bus.busy         = (state != S_IDLE);
    assign bus.rsp_z        = z_q;
    assign bus.rsp_equal    = eq_q;
    assign bus.rsp_overflow = ov_q;
    assign bus.rsp_zero     = zero_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: directed corner cases, backpressure,
// mid-shift reset and random traffic checked against a behavioural model.
module tb_alu_seq_unit;
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SLT = 3'd3;
    localparam logic [2:0] OP_SRL = 3'd4;
    localparam logic [2:0] OP_SRA = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    typedef struct packed {
        logic [31:0] z;
        logic        eq;
        logic        ov;
        logic        zr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_unit_if bus();
    alu_seq_unit_if bus4();

    alu_seq_unit #(.SHIFT_STEP(1)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
    alu_seq_unit #(.SHIFT_STEP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic [4:0] amt;
        e   = '0;
        amt = y[4:0];
        case (op)
            OP_AND: e.z = x & y;
            OP_ADD: begin
                e.z  = x + y;
                e.ov = (x[31] == y[31]) && (e.z[31] != x[31]);
            end
            OP_SUB: begin
                e.z  = x - y;
                e.ov = (x[31] != y[31]) && (e.z[31] != x[31]);
            end
            OP_SLT: e.z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_SRL: e.z = x >> amt;
            OP_SRA: e.z = $signed(x) >>> amt;
            OP_SLL: e.z = x << amt;
            default: return e;
        endcase
        e.eq = (x == y);
        e.zr = (e.z == 32'd0);
        return e;
    endfunction

    // One full transaction on the SHIFT_STEP=1 instance; exp_lat < 0 skips the latency check.
    task automatic run(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input int bp, input int exp_lat, input bit intrude);
        int   w;
        int   lat;
        exp_t e;
        @(negedge clk);
        bus.req_op    = op;
        bus.req_x     = x;
        bus.req_y     = y;
        bus.req_valid = 1'b1;
        bus.rsp_ready = (bp == 0);
        w = 0;
        while (!bus.req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            chk("accept_timeout", 32'd1, 32'd0);
            bus.req_valid = 1'b0;
            return;
        end
        sb.push_back(model(op, x, y));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom);
        bus.req_x     = $urandom;
        bus.req_y     = $urandom;
        lat = 1;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) begin
            chk("rsp_timeout", 32'd1, 32'd0);
            void'(sb.pop_front());
            return;
        end
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
        if (intrude) begin
            bus.req_op    = OP_ADD;
            bus.req_x     = 32'h1;
            bus.req_y     = 32'h2;
            bus.req_valid = 1'b1;
        end
        for (int i = 0; i < bp; i++) begin
            chk("hold_z", bus.rsp_z, sb[0].z);
            chk("hold_valid", bus.rsp_valid, 1'b1);
            chk("hold_req_ready", bus.req_ready, 1'b0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        e = sb.pop_front();
        chk("rsp_valid", bus.rsp_valid, 1'b1);
        chk("z", bus.rsp_z, e.z);
        chk("equal", bus.rsp_equal, e.eq);
        chk("overflow", bus.rsp_overflow, e.ov);
        chk("zero", bus.rsp_zero, e.zr);
        @(negedge clk);
        chk("rsp_drop", bus.rsp_valid, 1'b0);
        chk("ready_back", bus.req_ready, 1'b1);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        int          lat;
        int          el;
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.rsp_ready  = 1'b0;
        bus4.req_valid = 1'b0;
        bus4.req_op    = '0;
        bus4.req_x     = '0;
        bus4.req_y     = '0;
        bus4.rsp_ready = 1'b0;

        #12;
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_z", bus.rsp_z, 32'd0);
        chk("rst_flags", {bus.rsp_equal, bus.rsp_overflow, bus.rsp_zero}, 3'b000);
        @(negedge clk);
        rst = 1'b0;

        run(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1, 1'b0);
        run(OP_SUB, 32'h1234_5678, 32'h1234_5678, 1, 1, 1'b0);
        run(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 1'b0);
        run(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1, 1'b0);
        run(OP_SUB, 32'h8000_0000, 32'h0000_0001, 0, 1, 1'b0);
        run(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 2, 1, 1'b0);
        run(OP_SRA, 32'h8AC3_FB75, 32'h0000_001F, 0, 32, 1'b0);
        run(OP_SLL, 32'h1357_9BDF, 32'hFFFF_FFE0, 0, 1, 1'b0);
        run(OP_SRL, 32'h1357_9BDF, 32'h0000_0004, 0, 5, 1'b0);
        run(OP_SLL, 32'h8000_0001, 32'h0000_0001, 0, 2, 1'b0);
        run(OP_ADD, 32'hDEAD_BEEF, 32'h0000_0001, 10, 1, 1'b1);

        // SHIFT_STEP=4 instance: 31-bit arithmetic shift takes 8 shift cycles.
        @(negedge clk);
        bus4.req_op    = OP_SRA;
        bus4.req_x     = 32'h8AC3_FB75;
        bus4.req_y     = 32'h0000_001F;
        bus4.req_valid = 1'b1;
        bus4.rsp_ready = 1'b1;
        chk("s4_req_ready", bus4.req_ready, 1'b1);
        @(posedge clk);
        #1;
        bus4.req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus4.rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("s4_latency", lat, 9);
        chk("s4_z", bus4.rsp_z, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("s4_idle", bus4.req_ready, 1'b1);
        bus4.rsp_ready = 1'b0;

        // Reset in the middle of a long shift.
        @(negedge clk);
        bus.req_op    = OP_SRL;
        bus.req_x     = 32'hFFFF_0000;
        bus.req_y     = 32'd20;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mr_busy", bus.busy, 1'b0);
        chk("mr_rsp_valid", bus.rsp_valid, 1'b0);
        chk("mr_req_ready", bus.req_ready, 1'b1);
        chk("mr_z", bus.rsp_z, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 1'b0;
        sb.delete();
        run(OP_RSV, 32'h5555_5555, 32'h5555_5555, 0, 1, 1'b0);
        run(OP_RSV, 32'h0, 32'h0, 1, 1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = $urandom;
            y  = ($urandom_range(0, 3) == 0) ? x : $urandom;
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            el = ((op == OP_SRL) || (op == OP_SRA) || (op == OP_SLL)) ? 1 + int'(y[4:0]) : 1;
            run(op, x, y, $urandom_range(0, 3), el, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
